aes_sector_decrypt: RTL and testbench
=====================================

Name: aes_sector_decrypt

Overview:
Read-path counterpart of the encrypt-then-write sector path. Takes the ciphertext byte stream from the SD-card sector reader and packs 16 bytes into a 128-bit block. Drives an external ASMD_Decryption core through its start/done handshake, then unpacks the plaintext into an output byte stream. Tracks sector boundaries, pulses the core's reset between blocks, and has a watchdog on the decrypt wait.

Parameters:
SECTOR_BYTES, 512, bytes per sector; must be a multiple of 16.
CORE_RST_CYCLES, 2, cycles dec_core_rst is held high after each block.
TIMEOUT_CYCLES, 4096, maximum cycles to wait for dec_done before flagging an error.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
key_in  in  128  AES key; stable while a sector is in flight.
in_data  in  8  ciphertext byte from the sector reader.
in_valid  in  1  in_data valid.
in_ready  out  1  block accepts a byte (transfer when in_valid & in_ready).
out_data  out  8  plaintext byte.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts (transfer when out_valid & out_ready).
dec_start  out  1  one-cycle start pulse to the core's decrypt input.
dec_block  out  128  ciphertext block to the core's encrypted_text_in.
dec_done  in  1  core done; sticky until the core is reset.
dec_dout  in  128  core plaintext (Dout).
dec_core_rst  out  1  core-local reset; the parent ORs it with reset.
sector_done  out  1  one-cycle pulse after the last plaintext byte of a sector is accepted.
err_timeout  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Byte order is fixed: the first byte of a block maps to bits [127:120], the 16th to [7:0]. The output stream uses the same mapping, so plaintext [127:120] is emitted first. No byte reversal anywhere.
- Reset values: in_ready=0, out_valid=0, out_data=0, dec_start=0, dec_block=0, dec_core_rst=0, sector_done=0, err_timeout=0. All counters are 0 and the FSM is in FILL. in_ready rises on the first clock after reset deasserts.
- FSM states: FILL, START, WAIT, CLR, DRAIN.
- FILL:
  - in_ready=1; each transfer shifts in_data into dec_block and increments a 4-bit byte index.
  - The 16th transfer moves to START on the next edge; in_ready is 0 from that point.
- START:
  - dec_start=1 for exactly one cycle, dec_block held; then WAIT.
  - Watchdog counter cleared.
- WAIT:
  - dec_start=0. On dec_done=1, latch dec_dout into a 128-bit output register, then go to CLR.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without dec_done, pulse err_timeout, discard the block, advance the sector byte count by 16, and go to CLR. No output bytes are produced for that block.
- CLR:
  - dec_core_rst=1 for CORE_RST_CYCLES cycles.
  - Next state is DRAIN, or FILL after a timeout.
  - dec_done is ignored in this state.
- DRAIN:
  - out_valid=1 and out_data = output register [127:120]; the register shifts left 8 on each transfer.
  - out_valid holds and out_data is stable while out_ready=0.
  - After the 16th transfer, out_valid=0 and the FSM returns to FILL.
- Sector counter counts plaintext bytes transferred (plus 16 per timed-out block) and wraps at SECTOR_BYTES. sector_done pulses in the cycle after the wrap, including a wrap caused by a timeout.
- There is no overlap: in_ready=0 in START, WAIT, CLR and DRAIN. Throughput is one block per fill + core latency + CORE_RST_CYCLES + drain.
- If in_valid is asserted while in_ready=0, nothing is consumed and in_data is not sampled.
- Reset mid-operation clears everything immediately, including a partial block and the sector count. The parent's OR with reset keeps the core reset.
- key_in is not registered; the block passes nothing onto key_in, and the parent wires it straight to the core.

Decomposition:
- Shared package aes_stream_pkg holds:
  - the state encoding;
  - BLOCK_BYTES=16 and the 128-bit block width constant;
  - the byte-index width, also used by the write-side packer.
- One natural sub-module, aes_block_unpacker: the 128-to-8 shift register with the out_valid/out_ready handshake and a 16-transfer counter.
- The ASMD_Decryption core itself is instantiated by the parent, not inside this block.

Test Plan:
- FIPS-197 vector. Key 000102030405060708090a0b0c0d0e0f; feed bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a with the real core.
  - Requires dec_block=128'h69c4e0d86a7b0430d8cdb78070b4c55a at dec_start.
  - Output bytes must be 00 11 22 ... ff in order.
  - dec_core_rst must be high exactly 2 cycles before the first out_valid.
- Backpressure: randomly toggle out_ready and in_valid (50%) over 3 blocks.
  - Byte sequence identical to the unstalled run.
  - No byte duplicated or dropped.
  - dec_start seen exactly 3 times.
- Sector boundary: stream 512 bytes of repeating vector ciphertext.
  - 32 dec_start pulses.
  - sector_done pulses once, one cycle after the 512th output transfer.
- Timeout: stub core that never raises dec_done, TIMEOUT_CYCLES=64.
  - err_timeout pulses 64 cycles after dec_start, followed by the core-reset pulse.
  - No out_valid; in_ready returns to 1.
- Reset mid-block: assert reset after 7 input bytes and during DRAIN.
  - All outputs return to reset values asynchronously.
  - The next 16 bytes decode correctly.
  - sector_done is timed from the restart.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared block constants and sector read-path state encoding
package aes_stream_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = 128;
  localparam int BYTE_IDX_W  = $clog2(BLOCK_BYTES);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_START,
    ST_WAIT,
    ST_CLR,
    ST_DRAIN
  } dec_state_t;

endpackage

// File: rtl/aes_block_unpacker.sv
// rtl/aes_block_unpacker.sv - 128-bit block to byte stream shifter with valid/ready handshake
module aes_block_unpacker
  import aes_stream_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [BLOCK_BITS-1:0] load_data,
  input  logic                  active,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic                  last
);

  logic [BLOCK_BITS-1:0] shreg;
  logic [BYTE_IDX_W-1:0] cnt;
  logic                  xfer;

  // Most significant byte goes out first; bytes are only presented while the owner says so.
  assign out_valid = active;
  assign xfer      = active & out_ready;
  assign out_data  = shreg[BLOCK_BITS-1 -: 8];
  assign last      = xfer && (cnt == BYTE_IDX_W'(BLOCK_BYTES - 1));

  // Load a fresh plaintext block, or shift one byte out per accepted transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= '0;
    end else if (xfer) begin
      shreg <= {shreg[BLOCK_BITS-9:0], 8'h00};
      cnt   <= cnt + BYTE_IDX_W'(1);
    end
  end

endmodule

// File: rtl/aes_sector_decrypt.sv
// rtl/aes_sector_decrypt.sv - sector read path: pack ciphertext, run external decrypt core, stream plaintext
module aes_sector_decrypt
  import aes_stream_pkg::*;
#(
  parameter int SECTOR_BYTES    = 512,
  parameter int CORE_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BLOCK_BITS-1:0] key_in,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  dec_start,
  output logic [BLOCK_BITS-1:0] dec_block,
  input  logic                  dec_done,
  input  logic [BLOCK_BITS-1:0] dec_dout,
  output logic                  dec_core_rst,
  output logic                  sector_done,
  output logic                  err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CR_W = $clog2(CORE_RST_CYCLES + 1);
  localparam int SC_W = $clog2(SECTOR_BYTES);

  dec_state_t            state, state_next;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [WD_W-1:0]       wdog;
  logic [CR_W-1:0]       clr_cnt;
  logic [SC_W-1:0]       sec_cnt;
  logic                  timed_out;
  logic                  fill_xfer;
  logic                  load_out;
  logic                  drain_active;
  logic                  drain_last;
  logic                  out_xfer;
  logic                  key_unused;

  // The key is wired straight to the core by the parent; nothing here consumes it.
  assign key_unused = ^key_in;

  assign fill_xfer = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  aes_block_unpacker u_unpacker (
    .clock     (clock),
    .reset     (reset),
    .load      (load_out),
    .load_data (dec_dout),
    .active    (drain_active),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .last      (drain_last)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FILL;
    else       state <= state_next;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_next   = state;
    dec_start    = 1'b0;
    dec_core_rst = 1'b0;
    err_timeout  = 1'b0;
    load_out     = 1'b0;
    drain_active = 1'b0;
    case (state)
      ST_FILL: begin
        if (fill_xfer && byte_idx == BYTE_IDX_W'(BLOCK_BYTES - 1)) state_next = ST_START;
      end
      ST_START: begin
        dec_start  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (dec_done) begin
          load_out   = 1'b1;
          state_next = ST_CLR;
        end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout = 1'b1;
          state_next  = ST_CLR;
        end
      end
      ST_CLR: begin
        dec_core_rst = 1'b1;
        if (clr_cnt == CR_W'(CORE_RST_CYCLES - 1)) state_next = timed_out ? ST_FILL : ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_active = 1'b1;
        if (drain_last) state_next = ST_FILL;
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Input packing, watchdog and core-reset timing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b0;
      dec_block <= '0;
      byte_idx  <= '0;
      wdog      <= '0;
      clr_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      in_ready <= (state_next == ST_FILL);
      if (fill_xfer) begin
        dec_block <= {dec_block[BLOCK_BITS-9:0], in_data};
        byte_idx  <= byte_idx + BYTE_IDX_W'(1);
      end
      if (state == ST_START)     wdog <= '0;
      else if (state == ST_WAIT) wdog <= wdog + WD_W'(1);
      if (state == ST_WAIT) begin
        clr_cnt   <= '0;
        timed_out <= err_timeout;
      end else if (state == ST_CLR) begin
        clr_cnt <= clr_cnt + CR_W'(1);
      end
    end
  end

  // Sector byte count; a discarded block still occupies its 16 bytes of the sector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sec_cnt     <= '0;
      sector_done <= 1'b0;
    end else begin
      sector_done <= 1'b0;
      if (out_xfer) begin
        if (sec_cnt == SC_W'(SECTOR_BYTES - 1)) begin
          sec_cnt     <= '0;
          sector_done <= 1'b1;
        end else begin
          sec_cnt <= sec_cnt + SC_W'(1);
        end
      end else if (err_timeout) begin
        if (sec_cnt == SC_W'(SECTOR_BYTES - BLOCK_BYTES)) begin
          sec_cnt     <= '0;
          sector_done <= 1'b1;
        end else begin
          sec_cnt <= sec_cnt + SC_W'(BLOCK_BYTES);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_sector_decrypt.sv
// tb/tb_aes_sector_decrypt.sv - scoreboard bench for the sector decrypt read path
module tb_aes_sector_decrypt;

  localparam int SECTOR   = 512;
  localparam int TMO      = 64;
  localparam int CORE_LAT = 10;
  localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ASC_CT  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ASC_PT  = 128'h5a5b58595e5f5c5d5253505156575455;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         dec_start;
  logic [127:0] dec_block;
  logic         dec_done;
  logic [127:0] dec_dout;
  logic         dec_core_rst;
  logic         sector_done;
  logic         err_timeout;

  logic         rnd_out   = 1'b0;
  logic         core_dead = 1'b0;
  logic         busy;
  logic [7:0]   lat;
  logic [127:0] held;

  int checks = 0;
  int errors = 0;
  logic [7:0]   exp_q[$];
  logic [127:0] exp_blk[$];
  int cyc = 0, start_cyc = 0, ds_cnt = 0, to_cnt = 0, sd_cnt = 0, rst_run = 0, model_cnt = 0;
  bit sd_exp = 0, prev_ov = 0, chk_rst = 0;

  always #5 clock = ~clock;

  aes_sector_decrypt #(
    .SECTOR_BYTES(SECTOR), .CORE_RST_CYCLES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .key_in(KEY),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dec_start(dec_start), .dec_block(dec_block), .dec_done(dec_done), .dec_dout(dec_dout),
    .dec_core_rst(dec_core_rst), .sector_done(sector_done), .err_timeout(err_timeout)
  );

  // Stand-in decrypt core: fixed latency, sticky done, knows the FIPS-197 vector.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_done <= 1'b0; dec_dout <= '0; busy <= 1'b0; lat <= '0; held <= '0;
    end else if (dec_core_rst) begin
      dec_done <= 1'b0; busy <= 1'b0; lat <= '0;
    end else if (dec_start) begin
      busy <= 1'b1; lat <= '0; held <= dec_block;
    end else if (busy && !core_dead) begin
      if (lat == 8'(CORE_LAT - 1)) begin
        dec_done <= 1'b1;
        busy     <= 1'b0;
        dec_dout <= (held == FIPS_CT) ? FIPS_PT : (held ^ {16{8'h5a}});
      end else begin
        lat <= lat + 8'd1;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bytes/blocks and tracks sector and timeout timing.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete(); exp_blk.delete();
      model_cnt = 0; sd_exp = 0; prev_ov = 0; sd_cnt = 0; rst_run = 0; chk_rst = 0;
    end else begin
      cyc++;
      if (chk_rst) begin
        check("core_rst_after_timeout", 128'(dec_core_rst), 128'd1);
        chk_rst = 0;
      end
      if (sector_done || sd_exp) check("sector_done", 128'(sector_done), 128'(sd_exp));
      if (sector_done) sd_cnt++;
      sd_exp = 0;
      if (dec_start) begin
        ds_cnt++; start_cyc = cyc; rst_run = 0;
        if (exp_blk.size() == 0) begin
          checks++; errors++;
          $display("FAIL dec_start_unexpected: got block %0h expected none", dec_block);
        end else check("dec_block", dec_block, exp_blk.pop_front());
      end
      if (dec_core_rst) rst_run++;
      if (out_valid && !prev_ov) check("core_rst_cycles", 128'(rst_run), 128'd2);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got byte %0h expected none", out_data);
        end else check("out_data", 128'(out_data), 128'(exp_q.pop_front()));
        model_cnt++;
        if (model_cnt == SECTOR) begin model_cnt = 0; sd_exp = 1; end
      end
      if (err_timeout) begin
        to_cnt++;
        check("timeout_latency", 128'(cyc - start_cyc), 128'(TMO));
        chk_rst = 1;
        model_cnt += 16;
        if (model_cnt >= SECTOR) begin model_cnt -= SECTOR; sd_exp = 1; end
      end
    end
  end

  task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, input int n,
                            input bit rnd, input bit expect_out);
    int  i = 0;
    int  guard = 0;
    bit  will;
    if (n == 16) begin
      exp_blk.push_back(ct);
      if (expect_out) for (int k = 0; k < 16; k++) exp_q.push_back(pt[127-8*k -: 8]);
    end
    @(posedge clock); #1;
    while (i < n && guard < 3000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? ct[127-8*i -: 8] : 8'($urandom);
      will     = in_valid && in_ready;
      @(posedge clock); #1;
      if (will) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (i < n) begin
      checks++; errors++;
      $display("FAIL send_block: got %0d bytes accepted expected %0d", i, n);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(exp_q.size() == 0 && in_ready) && g < 5000) begin
      @(posedge clock); #1;
      g++;
    end
    if (g >= 5000) begin
      checks++; errors++;
      $display("FAIL wait_idle: got %0d bytes pending expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", 128'(out_data), 128'd0);
    check("rst_dec_start", 128'(dec_start), 128'd0);
    check("rst_dec_block", dec_block, 128'd0);
    check("rst_dec_core_rst", 128'(dec_core_rst), 128'd0);
    check("rst_sector_done", 128'(sector_done), 128'd0);
    check("rst_err_timeout", 128'(err_timeout), 128'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int ds0, to0, g;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    do_reset();
    check("in_ready_before_clock", 128'(in_ready), 128'd0);
    @(posedge clock); #1;
    check("in_ready_after_clock", 128'(in_ready), 128'd1);

    // FIPS-197 vector, no stalls.
    send_block(FIPS_CT, FIPS_PT, 16, 0, 1);
    wait_idle();

    // Random stalls on both sides across three blocks.
    ds0 = ds_cnt;
    rnd_out = 1'b1;
    send_block(FIPS_CT, FIPS_PT, 16, 1, 1);
    send_block(ASC_CT, ASC_PT, 16, 1, 1);
    send_block(FIPS_CT, FIPS_PT, 16, 1, 1);
    wait_idle();
    rnd_out = 1'b0;
    check("bp_dec_start_count", 128'(ds_cnt - ds0), 128'd3);

    // Core never finishes: watchdog fires, block discarded.
    core_dead = 1'b1;
    to0 = to_cnt;
    send_block(ASC_CT, ASC_PT, 16, 0, 0);
    wait_idle();
    check("in_ready_after_timeout", 128'(in_ready), 128'd1);
    check("timeout_count", 128'(to_cnt - to0), 128'd1);
    core_dead = 1'b0;

    // Reset after 7 bytes of a block, then again in the middle of a drain.
    send_block(FIPS_CT, FIPS_PT, 7, 0, 0);
    do_reset();
    send_block(FIPS_CT, FIPS_PT, 16, 0, 1);
    g = 0;
    while (exp_q.size() > 10 && g < 500) begin @(posedge clock); #1; g++; end
    do_reset();

    // Full sector from the restart: one sector_done after the 512th byte.
    ds0 = ds_cnt;
    for (int b = 0; b < 32; b++) send_block(FIPS_CT, FIPS_PT, 16, 0, 1);
    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    check("sector_dec_start_count", 128'(ds_cnt - ds0), 128'd32);
    check("sector_done_count", 128'(sd_cnt), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
